// File: rtl/fir_mac_sequencer.sv
// Sequential FIR filter: one shared multiply-accumulate unit walks NTAPS taps per sample,
// with a runtime-writable coefficient bank and a saturated 16-bit result.
module fir_mac_sequencer #(
    parameter int NTAPS = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              y,
    input  logic                     cfg_we,
    input  logic [$clog2(NTAPS)-1:0] cfg_addr,
    input  logic [CW-1:0]            cfg_data,
    output logic                     cfg_err,
    input  logic                     flush,
    output logic                     busy
);

    localparam int AW   = $clog2(NTAPS);
    localparam int PW   = CW + 8;
    localparam int ACCW = CW + 8 + AW;
    localparam int EW   = (ACCW > 17) ? ACCW : 17;

    localparam logic signed [EW-1:0] SAT_MAX = EW'(32767);
    localparam logic signed [EW-1:0] SAT_MIN = EW'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          k_q, k_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [15:0]            y_q, y_d;
    logic                   cfg_err_q, cfg_err_d;
    logic signed [CW-1:0]   coeff_q [NTAPS];
    logic signed [CW-1:0]   coeff_d [NTAPS];
    logic signed [7:0]      dl_q [NTAPS];
    logic signed [7:0]      dl_d [NTAPS];

    logic signed [PW-1:0]   product;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [EW-1:0]   sum_ext;
    logic [15:0]            sum_sat;
    logic                   addr_ok;
    logic                   last_tap;

    function automatic logic signed [CW-1:0] coeff_init(input int idx);
        case (idx)
            0:       coeff_init = CW'(2);
            1:       coeff_init = CW'(4);
            2:       coeff_init = CW'(4);
            3:       coeff_init = CW'(2);
            default: coeff_init = '0;
        endcase
    endfunction

    // Operands are widened before multiplying so the product never wraps.
    always_comb begin
        product  = PW'(coeff_q[k_q]) * PW'(dl_q[k_q]);
        acc_sum  = acc_q + ACCW'(product);
        sum_ext  = EW'(acc_sum);
        if (sum_ext > SAT_MAX) begin
            sum_sat = 16'h7fff;
        end else if (sum_ext < SAT_MIN) begin
            sum_sat = 16'h8000;
        end else begin
            sum_sat = sum_ext[15:0];
        end
        addr_ok  = ({1'b0, cfg_addr} < (AW+1)'(NTAPS));
        last_tap = (k_q == AW'(NTAPS - 1));
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        y_d       = y_q;
        cfg_err_d = 1'b0;
        coeff_d   = coeff_q;
        dl_d      = dl_q;

        if (cfg_we) begin
            if (state_q == IDLE && addr_ok) begin
                coeff_d[cfg_addr] = $signed(cfg_data);
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (flush) begin
                    for (int i = 0; i < NTAPS; i++) begin
                        dl_d[i] = '0;
                    end
                end
                // A flush coinciding with an accept leaves only the new sample in the line.
                if (in_valid) begin
                    for (int i = NTAPS - 1; i > 0; i--) begin
                        dl_d[i] = flush ? '0 : dl_q[i-1];
                    end
                    dl_d[0] = $signed(x);
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                if (last_tap) begin
                    y_d     = sum_sat;
                    k_d     = '0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                coeff_q[i] <= coeff_init(i);
                dl_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            cfg_err_q <= cfg_err_d;
            coeff_q   <= coeff_d;
            dl_q      <= dl_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign y         = y_q;
    assign cfg_err   = cfg_err_q;

endmodule
